// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial ALU family: FSM state encoding and
// the counter-width helper.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Bit counter width: clog2 of the operand width, never below one bit.
   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder cell; the only place in the serial adder where
// sum and carry are computed.
module full_adder (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = x ^ y ^ ci;
   assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: operands are shifted LSB-first through a single
// full_adder cell with a registered carry, one bit per clock.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] z,
   output logic             cout
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] r_sh_q, r_sh_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] z_q, z_d;
   logic             cout_q, cout_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             sum_bit;
   logic             cell_co;

   // Shift right by one and insert the new bit at the MSB; written this
   // way so WIDTH=1 needs no special-cased slice.
   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] r,
                                                 input logic            bit_in);
      logic [WIDTH-1:0] t;
      t = r >> 1;
      t[WIDTH-1] = bit_in;
      return t;
   endfunction

   full_adder u_cell (
      .x  (a_sh_q[0]),
      .y  (b_sh_q[0]),
      .ci (carry_q),
      .s  (sum_bit),
      .co (cell_co)
   );

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      r_sh_d  = r_sh_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      z_d     = z_q;
      cout_d  = cout_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready_q) begin
               a_sh_d  = a;
               b_sh_d  = b;
               carry_d = cin;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            r_sh_d  = shift_in(r_sh_q, sum_bit);
            carry_d = cell_co;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               z_d     = shift_in(r_sh_q, sum_bit);
               cout_d  = cell_co;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Handshake outputs are registered from the next state so no input
      // reaches them combinationally.
      in_ready_d  = (state_d == ST_IDLE);
      out_valid_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         r_sh_q      <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         z_q         <= '0;
         cout_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_sh_q      <= a_sh_d;
         b_sh_q      <= b_sh_d;
         r_sh_q      <= r_sh_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         z_q         <= z_d;
         cout_q      <= cout_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign z         = z_q;
   assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: an 8-bit and a 1-bit instance checked against
// plain integer addition of the operands captured at accept time.
module tb_serial_adder;

   logic       clk;
   logic       rst;

   logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8;
   logic [7:0] a8, b8, z8;

   logic       in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1;
   logic [0:0] a1, b1, z1;

   int checks;
   int passes;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .a         (a8),
      .b         (b8),
      .cin       (cin8),
      .out_valid (out_valid8),
      .out_ready (out_ready8),
      .z         (z8),
      .cout      (cout8)
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid1),
      .in_ready  (in_ready1),
      .a         (a1),
      .b         (b1),
      .cin       (cin1),
      .out_valid (out_valid1),
      .out_ready (out_ready1),
      .z         (z1),
      .cout      (cout1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d passed=%0d", checks, passes);
      $fatal(1, "watchdog");
   end

   function automatic logic [8:0] model_sum(input logic [7:0] x, input logic [7:0] y, input logic c);
      return {1'b0, x} + {1'b0, y} + {8'd0, c};
   endfunction

   // Drives one 8-bit accept and waits (bounded) for out_valid; the result
   // is left pending so the caller decides when to consume it.
   task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                       input bit scramble, output int lat,
                       output logic [7:0] oz, output logic oc);
      int n;
      n = 0;
      while (!in_ready8 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      a8 = ta; b8 = tb; cin8 = tc; in_valid8 = 1'b1;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      n = 0;
      while (!out_valid8 && n < 64) begin
         if (scramble) begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            in_valid8 = 1'($urandom);
         end
         @(posedge clk); #1; n++;
      end
      in_valid8 = 1'b0;
      lat = out_valid8 ? n : -1;
      oz  = z8;
      oc  = cout8;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({in_ready8, out_valid8, z8, cout8} !== 11'd0)
         $display("FAIL reset8: in_ready=%b out_valid=%b z=%h cout=%b, want all 0", in_ready8, out_valid8, z8, cout8);
      else passes++;
      checks++;
      if ({in_ready1, out_valid1, z1, cout1} !== 4'd0)
         $display("FAIL reset1: in_ready=%b out_valid=%b z=%b cout=%b, want all 0", in_ready1, out_valid1, z1, cout1);
      else passes++;
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (in_ready8 !== 1'b1 || in_ready1 !== 1'b1)
         $display("FAIL reset_release: in_ready8=%b in_ready1=%b, want 1", in_ready8, in_ready1);
      else passes++;
   endtask

   task automatic test_directed;
      logic [7:0] va [3] = '{8'h5A, 8'hFF, 8'hFF};
      logic [7:0] vb [3] = '{8'h3C, 8'h01, 8'hFF};
      logic       vc [3] = '{1'b0, 1'b0, 1'b1};
      logic [8:0] e;
      logic [7:0] oz;
      logic       oc;
      int         lat;
      out_ready8 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         e = model_sum(va[i], vb[i], vc[i]);
         run8(va[i], vb[i], vc[i], 1'b0, lat, oz, oc);
         checks++;
         if (lat !== 8) $display("FAIL latency8[%0d]: got %0d cycles, want 8", i, lat);
         else passes++;
         checks++;
         if ({oc, oz} !== e)
            $display("FAIL directed_sum[%0d]: got cout=%b z=%h, want cout=%b z=%h", i, oc, oz, e[8], e[7:0]);
         else passes++;
         @(posedge clk); #1;
         checks++;
         if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1)
            $display("FAIL done_one_cycle[%0d]: out_valid=%b in_ready=%b, want 0/1", i, out_valid8, in_ready8);
         else passes++;
      end
   endtask

   task automatic test_random;
      logic [7:0] ta, tb, oz;
      logic       tc, oc;
      logic [8:0] e;
      int         lat;
      out_ready8 = 1'b1;
      for (int i = 0; i < 12; i++) begin
         ta = 8'($urandom); tb = 8'($urandom); tc = 1'($urandom);
         e = model_sum(ta, tb, tc);
         run8(ta, tb, tc, 1'b0, lat, oz, oc);
         checks++;
         if (lat !== 8 || {oc, oz} !== e)
            $display("FAIL random[%0d]: %h+%h+%b got lat=%0d cout=%b z=%h, want lat=8 cout=%b z=%h",
                     i, ta, tb, tc, lat, oc, oz, e[8], e[7:0]);
         else passes++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_operand_change;
      logic [7:0] ta, tb, oz;
      logic       tc, oc;
      logic [8:0] e;
      int         lat;
      out_ready8 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ta = 8'($urandom); tb = 8'($urandom); tc = 1'($urandom);
         e = model_sum(ta, tb, tc);
         run8(ta, tb, tc, 1'b1, lat, oz, oc);
         checks++;
         if (lat !== 8 || {oc, oz} !== e)
            $display("FAIL operand_change[%0d]: got lat=%0d cout=%b z=%h, want lat=8 cout=%b z=%h",
                     i, lat, oc, oz, e[8], e[7:0]);
         else passes++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure;
      logic [7:0] oz;
      logic       oc;
      int         lat;
      int         bad;
      out_ready8 = 1'b0;
      run8(8'h12, 8'h34, 1'b0, 1'b0, lat, oz, oc);
      checks++;
      if (lat !== 8 || oz !== 8'h46 || oc !== 1'b0)
         $display("FAIL bp_result: got lat=%0d z=%h cout=%b, want lat=8 z=46 cout=0", lat, oz, oc);
      else passes++;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         in_valid8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
         @(posedge clk); #1;
         if (out_valid8 !== 1'b1 || z8 !== 8'h46 || in_ready8 !== 1'b0) bad++;
      end
      in_valid8 = 1'b0;
      checks++;
      if (bad != 0)
         $display("FAIL bp_hold: %0d of 5 stalled cycles wrong (last out_valid=%b z=%h in_ready=%b), want 1/46/0",
                  bad, out_valid8, z8, in_ready8);
      else passes++;
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || z8 !== 8'h46)
         $display("FAIL bp_release: out_valid=%b in_ready=%b z=%h, want 0/1/46", out_valid8, in_ready8, z8);
      else passes++;
   endtask

   task automatic test_reset_mid_run;
      logic [7:0] oz;
      logic       oc;
      int         lat;
      int         pulses;
      out_ready8 = 1'b1;
      a8 = 8'hA5; b8 = 8'h7E; cin8 = 1'b1; in_valid8 = 1'b1;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid8 !== 1'b0 || z8 !== 8'h00 || cout8 !== 1'b0 || in_ready8 !== 1'b0)
         $display("FAIL rst_mid_run: out_valid=%b z=%h cout=%b in_ready=%b, want 0/00/0/0",
                  out_valid8, z8, cout8, in_ready8);
      else passes++;
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (out_valid8 !== 1'b0) pulses++;
      end
      checks++;
      if (pulses != 0) $display("FAIL rst_discard: out_valid high in %0d cycles after reset, want 0", pulses);
      else passes++;
      run8(8'h01, 8'h01, 1'b0, 1'b0, lat, oz, oc);
      checks++;
      if (lat !== 8 || oz !== 8'h02 || oc !== 1'b0)
         $display("FAIL rst_fresh_add: got lat=%0d z=%h cout=%b, want lat=8 z=02 cout=0", lat, oz, oc);
      else passes++;
      @(posedge clk); #1;
   endtask

   task automatic test_width1;
      logic [1:0] e;
      int         n;
      out_ready1 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         n = 0;
         while (!in_ready1 && n < 20) begin
            @(posedge clk); #1; n++;
         end
         a1 = 1'(i >> 2); b1 = 1'(i >> 1); cin1 = 1'(i);
         e = 2'(a1) + 2'(b1) + 2'(cin1);
         in_valid1 = 1'b1;
         @(posedge clk); #1;
         in_valid1 = 1'b0;
         @(posedge clk); #1;
         checks++;
         if (out_valid1 !== 1'b1 || {cout1, z1} !== e)
            $display("FAIL width1[%0d]: out_valid=%b cout=%b z=%b, want 1/%b/%b",
                     i, out_valid1, cout1, z1, e[1], e[0]);
         else passes++;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      checks = 0; passes = 0;
      rst = 1'b1;
      in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; out_ready8 = 1'b1;
      in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b1;
      test_reset;
      test_directed;
      test_random;
      test_operand_change;
      test_backpressure;
      test_reset_mid_run;
      test_width1;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
